// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH delta-sigma modulator.
// Holds the order type, stage limit and coefficient/range functions.
package mash_pkg;

  localparam int MAX_ORDER_LIMIT = 4;

  typedef logic [2:0] order_t;

  // Output code range for an order-k cascade
  function automatic int out_max(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int out_min(input int k);
    return 1 - (1 << (k - 1));
  endfunction

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) begin
      r = r * (n - i) / (i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mash_efm_stage.sv
// One error-feedback accumulator of the MASH cascade plus its own
// carry history, producing its (1-z^-1)^(IDX-1) cancellation term.
module mash_efm_stage
  import mash_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_ORDER = 3,
  parameter int IDX       = 1,
  parameter int DAC_BW    = 5
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  logic                     step,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH-1:0]         err,
  output logic signed [DAC_BW-1:0] term
);

  localparam int HD = (MAX_ORDER > 1) ? MAX_ORDER - 1 : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [HD-1:0]    hist;
  logic [HD:0]      hist_ext;
  int               t;

  assign sum      = {1'b0, acc} + {1'b0, in_data};
  assign carry    = clear ? 1'b0 : sum[WIDTH];
  assign err      = clear ? '0 : sum[WIDTH-1:0];
  assign hist_ext = {hist, carry};

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      acc  <= '0;
      hist <= '0;
    end else if (step) begin
      if (clear) begin
        acc  <= '0;
        hist <= '0;
      end else begin
        acc  <= sum[WIDTH-1:0];
        hist <= hist_ext[HD-1:0];
      end
    end
  end

  // hist_ext[j] is the carry j steps back; binomial weights alternate sign
  always_comb begin
    t = carry ? 1 : 0;
    for (int j = 1; j < MAX_ORDER; j++) begin
      if (j < IDX && hist_ext[j]) begin
        t = j[0] ? t - binom(IDX - 1, j)
                 : t + binom(IDX - 1, j);
      end
    end
    term = clear ? '0 : DAC_BW'(t);
  end

endmodule

// File: rtl/mash_nstage.sv
// Run-time selectable MASH delta-sigma modulator (order 1..MAX_ORDER)
// between an AXI-Stream sample source and a signed DAC code stream.
module mash_nstage
  import mash_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_ORDER = 3,
  parameter int DAC_BW    = 5,
  parameter int FREE_RUN  = 0
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  order_t                   cfg_order,
  input  logic [WIDTH-1:0]         s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  output logic signed [DAC_BW-1:0] m_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready
);

  if (MAX_ORDER < 1 || MAX_ORDER > MAX_ORDER_LIMIT) begin : g_bad_order
    $error("mash_nstage: MAX_ORDER out of range 1..4");
  end

  if (DAC_BW < MAX_ORDER + 1) begin : g_bad_bw
    $error("mash_nstage: DAC_BW must be >= MAX_ORDER+1");
  end

  order_t                   eff_order;
  logic                     slot_free;
  logic                     accept;
  logic                     step;
  logic                     started;
  logic [WIDTH-1:0]         held;
  logic [WIDTH-1:0]         sample;
  logic [WIDTH-1:0]         chain [MAX_ORDER+1];
  logic signed [DAC_BW-1:0] terms [MAX_ORDER];
  logic signed [DAC_BW-1:0] y;
  logic                     unused_tail;

  assign eff_order = (cfg_order == '0 || cfg_order > order_t'(MAX_ORDER))
                   ? order_t'(MAX_ORDER) : cfg_order;

  assign slot_free          = !m_axis_data_tvalid || m_axis_data_tready;
  assign s_axis_data_tready = slot_free;
  assign accept             = s_axis_data_tvalid && slot_free;
  assign sample             = accept ? s_axis_data_tdata : held;

  // Free-run keeps stepping on the held sample once one has arrived
  assign step = (FREE_RUN != 0) ? (slot_free && (accept || started))
                                : accept;

  assign chain[0]    = sample;
  assign unused_tail = ^chain[MAX_ORDER];

  for (genvar i = 0; i < MAX_ORDER; i++) begin : g_stage
    logic en;
    assign en = order_t'(i) < eff_order;

    mash_efm_stage #(
      .WIDTH     (WIDTH),
      .MAX_ORDER (MAX_ORDER),
      .IDX       (i + 1),
      .DAC_BW    (DAC_BW)
    ) u_stage (
      .aclk    (aclk),
      .arst_n  (arst_n),
      .step    (step),
      .clear   (!en),
      .in_data (chain[i]),
      .err     (chain[i+1]),
      .term    (terms[i])
    );
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < MAX_ORDER; i++) begin
      y = y + terms[i];
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      held    <= '0;
      started <= 1'b0;
    end else if (accept) begin
      held    <= s_axis_data_tdata;
      started <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else if (step) begin
      m_axis_data_tdata  <= y;
      m_axis_data_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash_nstage.sv
// Scoreboard bench for mash_nstage: random and directed streams
// against a carry-sequence reference model of the MASH cascade.
module tb_mash_nstage;

  logic              aclk;
  logic              arst_n;
  logic [2:0]        cfg_order;
  logic [15:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic signed [4:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  logic [2:0]        cfg_order2;
  logic [7:0]        s_tdata2;
  logic              s_tvalid2;
  logic              s_tready2;
  logic signed [4:0] m_tdata2;
  logic              m_tvalid2;
  logic              m_tready2;

  int errors = 0;
  int checks = 0;
  int exp_q [$];
  int cap [$];

  longint macc [2][4];
  int     ch   [2][4][4];

  mash_nstage #(
    .WIDTH(16), .MAX_ORDER(3), .DAC_BW(5), .FREE_RUN(0)
  ) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_order          (cfg_order),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready)
  );

  mash_nstage #(
    .WIDTH(8), .MAX_ORDER(3), .DAC_BW(5), .FREE_RUN(1)
  ) dut2 (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_order          (cfg_order2),
    .s_axis_data_tdata  (s_tdata2),
    .s_axis_data_tvalid (s_tvalid2),
    .s_axis_data_tready (s_tready2),
    .m_axis_data_tdata  (m_tdata2),
    .m_axis_data_tvalid (m_tvalid2),
    .m_axis_data_tready (m_tready2)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input int id);
    for (int k = 0; k < 4; k++) begin
      macc[id][k] = 0;
      for (int h = 0; h < 4; h++) ch[id][k][h] = 0;
    end
  endfunction

  // Cascade of modulo-2^w accumulators; output is each stage's carry
  // stream differenced (k-1) times, summed over the active stages
  function automatic int model_step(input int id, input int w,
                                    input int x, input int order);
    int     eff;
    longint m;
    longint in;
    longint v;
    int     y;
    int     seq [4];
    eff = (order == 0 || order > 3) ? 3 : order;
    m   = longint'(1) << w;
    in  = x;
    y   = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < eff) begin
        v = macc[id][k] + in;
        for (int h = 3; h > 0; h--) ch[id][k][h] = ch[id][k][h-1];
        ch[id][k][0] = int'(v / m);
        macc[id][k]  = v % m;
        in           = macc[id][k];
      end else begin
        macc[id][k] = 0;
        for (int h = 0; h < 4; h++) ch[id][k][h] = 0;
        in = 0;
      end
    end
    for (int k = 0; k < eff; k++) begin
      for (int h = 0; h < 4; h++) seq[h] = ch[id][k][h];
      for (int r = 0; r < k; r++) begin
        for (int i = 0; i < 3; i++) seq[i] = seq[i] - seq[i+1];
      end
      y += seq[0];
    end
    return y;
  endfunction

  // Monitor: pops one expectation per completed output transfer
  initial begin : monitor
    bit stalled;
    int held_d;
    stalled = 1'b0;
    held_d  = 0;
    forever begin
      @(negedge aclk);
      #4;
      if (!arst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("bp_hold_data", int'(m_tdata), held_d);
          chk("bp_hold_valid", int'(m_tvalid), 1);
        end
        if (m_tvalid && !m_tready) begin
          chk("bp_s_tready", int'(s_tready), 0);
          stalled = 1'b1;
          held_d  = int'(m_tdata);
        end else begin
          stalled = 1'b0;
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0d expected none",
                     int'(m_tdata));
          end else begin
            chk("data", int'(m_tdata), exp_q.pop_front());
          end
          cap.push_back(int'(m_tdata));
        end
      end
    end
  end

  task automatic drive(input int n, input int tv, input int tr,
                       input bit rnd, input logic [15:0] d,
                       input bit rord);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_tvalid = ($urandom_range(99) < tv);
      s_tdata  = rnd ? 16'($urandom) : d;
      m_tready = ($urandom_range(99) < tr);
      if (rord && $urandom_range(15) == 0) begin
        cfg_order = 3'($urandom_range(7));
      end
      #1;
      if (s_tvalid && s_tready) begin
        exp_q.push_back(model_step(0, 16, int'(s_tdata),
                                   int'(cfg_order)));
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic reset_all();
    @(negedge aclk);
    arst_n    = 1'b0;
    s_tvalid  = 1'b0;
    s_tvalid2 = 1'b0;
    m_tready  = 1'b1;
    m_tready2 = 1'b1;
    @(negedge aclk);
    exp_q.delete();
    cap.delete();
    model_reset(0);
    model_reset(1);
    arst_n = 1'b1;
  endtask

  task automatic chk_pat(input string nm, input int pat [4], input int n);
    chk({nm, "_len"}, cap.size(), n);
    for (int i = 0; i < n && i < cap.size(); i++) begin
      chk(nm, cap[i], pat[i % 4]);
    end
  endtask

  initial begin : stim
    int k;
    int d;
    int sum;
    arst_n     = 1'b0;
    cfg_order  = 3'd1;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b1;
    cfg_order2 = 3'd1;
    s_tdata2   = '0;
    s_tvalid2  = 1'b0;
    m_tready2  = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge aclk);
    chk("reset_valid", int'(m_tvalid), 0);
    chk("reset_data", int'(m_tdata), 0);
    arst_n = 1'b1;
    @(negedge aclk);
    chk("reset_s_tready", int'(s_tready), 1);

    // Order 1, 0.25 input
    reset_all();
    cfg_order = 3'd1;
    chk("pre_valid", int'(m_tvalid), 0);
    drive(1, 100, 100, 1'b0, 16'h4000, 1'b0);
    @(negedge aclk);
    #1;
    chk("latency_valid", int'(m_tvalid), 1);
    s_tvalid = 1'b0;
    drive(15, 100, 100, 1'b0, 16'h4000, 1'b0);
    drain(4);
    chk_pat("t1_pat", '{0, 0, 0, 1}, 16);

    // Order 2, 0.5 input
    reset_all();
    cfg_order = 3'd2;
    drive(16, 100, 100, 1'b0, 16'h8000, 1'b0);
    drain(4);
    chk_pat("t2_pat", '{0, 1, 1, 0}, 16);

    // Five-cycle output stall mid-stream
    reset_all();
    cfg_order = 3'd2;
    drive(6, 100, 100, 1'b0, 16'h8000, 1'b0);
    drive(5, 100, 0, 1'b0, 16'h8000, 1'b0);
    drive(7, 100, 100, 1'b0, 16'h8000, 1'b0);
    drain(4);
    chk_pat("t4_pat", '{0, 1, 1, 0}, 13);

    // Random data, handshakes and order changes
    reset_all();
    cfg_order = 3'd3;
    drive(400, 70, 70, 1'b1, 16'h0000, 1'b1);
    drain(6);

    // Async reset mid-stream, then order 1
    reset_all();
    cfg_order = 3'd3;
    drive(20, 80, 80, 1'b1, 16'h0000, 1'b0);
    @(posedge aclk);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(m_tvalid), 0);
    chk("t6_rst_data", int'(m_tdata), 0);
    chk("t6_rst_acc1", int'(dut.g_stage[0].u_stage.acc), 0);
    chk("t6_rst_acc2", int'(dut.g_stage[1].u_stage.acc), 0);
    chk("t6_rst_acc3", int'(dut.g_stage[2].u_stage.acc), 0);
    exp_q.delete();
    cap.delete();
    model_reset(0);
    cfg_order = 3'd1;
    s_tvalid  = 1'b0;
    @(negedge aclk);
    arst_n = 1'b1;
    drive(16, 100, 100, 1'b0, 16'h4000, 1'b0);
    drain(4);
    chk_pat("t6_pat", '{0, 0, 0, 1}, 16);
    chk("t6_acc2", int'(dut.g_stage[1].u_stage.acc), 0);
    chk("t6_acc3", int'(dut.g_stage[2].u_stage.acc), 0);

    // Free-run: one sample then held, with a short stall
    reset_all();
    cfg_order2 = 3'd1;
    @(negedge aclk);
    s_tvalid2 = 1'b1;
    s_tdata2  = 8'h40;
    m_tready2 = 1'b1;
    k = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge aclk);
      s_tvalid2 = 1'b0;
      m_tready2 = (i >= 8 && i < 11) ? 1'b0 : 1'b1;
      #4;
      chk("t5_valid", int'(m_tvalid2), 1);
      chk("t5_data", int'(m_tdata2), ((k - 1) % 4 == 3) ? 1 : 0);
      chk("t5_s_tready", int'(s_tready2), int'(m_tready2));
      if (!m_tvalid2 || m_tready2) k++;
    end

    // WIDTH=8 order 3, constant 0x25 over one full period
    reset_all();
    cfg_order2 = 3'd3;
    @(negedge aclk);
    s_tvalid2 = 1'b1;
    s_tdata2  = 8'h25;
    m_tready2 = 1'b1;
    sum = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge aclk);
      s_tvalid2 = 1'b0;
      #4;
      d = int'(m_tdata2);
      sum += d;
      chk("t3_data", d, model_step(1, 8, 'h25, 3));
      chk("t3_range", (d >= -3 && d <= 4) ? 1 : 0, 1);
    end
    chk("t3_sum_window", (sum >= 'h25 - 1 && sum <= 'h25 + 2) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
